// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings shared by ahb_master and ahb_sram_slave,
// plus the SRAM slave FSM state type and its byte-enable helper.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    SRAM_IDLE,
    SRAM_WAIT,
    SRAM_DATA,
    SRAM_ERR1,
    SRAM_ERR2
  } sram_state_e;

  // Little-endian lane enables for a legal (aligned) transfer.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << off;
      HSIZE_HALF: byte_en = off[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite signal bundle between a master (or decoder/
// interconnect) and the SRAM slave.
//   master modport: drives address/control/write data and bus-wide hready
//   slave  modport: drives hreadyout, hresp, hrdata
interface ahb_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic                  hreadyout;
  logic                  hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_bytelane.sv
// ahb_sram_bytelane: MEM_DEPTH x 32 RAM split into four byte lanes.
//   hclk  - write clock
//   we/be - write strobe and per-lane enables (synchronous write)
//   addr  - word index shared by write and read
//   wdata - write word; rdata - asynchronous read word
// Contents are not reset.
module ahb_sram_bytelane #(
  parameter  int MEM_DEPTH = 256,
  localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
  input  logic             hclk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);
  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge hclk)
      if (we && be[l]) mem[addr] <= wdata[8*l +: 8];

    assign rdata[8*l +: 8] = mem[addr];
  end
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite subordinate backed by a word-organised RAM.
//   hclk, hresetn - clock, async active-low reset
//   bus (slave)   - AHB-Lite address/control/data; hreadyout low for
//                   WAIT_STATES cycles per OKAY data phase, two-cycle ERROR
//                   for oversize, misaligned or out-of-range accesses.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic              hclk,
  input logic              hresetn,
  ahb_sram_slave_if.slave  bus
);
  localparam int         IDX_W   = $clog2(MEM_DEPTH);
  // Counter is loaded with WS-1 on entry so WAIT lasts exactly WS cycles.
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  sram_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q;
  logic [1:0]            off_q;
  logic [2:0]            size_q;
  logic                  write_q;

  logic                  accept, take, illegal, misalign, out_of_range;
  logic                  ready;
  logic [DATA_WIDTH-1:0] rd_word;

  assign accept       = bus.hsel & bus.hready & bus.htrans[1];
  assign ready        = (state_q != SRAM_WAIT) && (state_q != SRAM_ERR1);
  // Only IDLE/DATA/ERR2 can start a new transfer; guards against a foreign
  // hready while this slave is still stalling.
  assign take         = accept & ready;
  assign misalign     = ((bus.hsize == HSIZE_HALF) && bus.haddr[0]) ||
                        ((bus.hsize == HSIZE_WORD) && (bus.haddr[1:0] != 2'b00));
  assign out_of_range = |bus.haddr[ADDR_WIDTH-1:IDX_W+2];
  assign illegal      = (bus.hsize > HSIZE_WORD) | misalign | out_of_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SRAM_WAIT: begin
        if (cnt_q == 4'd0) state_d = SRAM_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SRAM_ERR1: state_d = SRAM_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all complete this cycle and may pipeline the next.
        state_d = SRAM_IDLE;
        if (accept) begin
          if (illegal) begin
            state_d = SRAM_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = SRAM_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = SRAM_DATA;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= SRAM_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      size_q  <= 3'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        idx_q   <= bus.haddr[IDX_W+1:2];
        off_q   <= bus.haddr[1:0];
        size_q  <= bus.hsize;
        write_q <= bus.hwrite;
      end
    end
  end

  ahb_sram_bytelane #(.MEM_DEPTH(MEM_DEPTH)) u_ram (
    .hclk  (hclk),
    .we    ((state_q == SRAM_DATA) && write_q),
    .be    (byte_en(size_q, off_q)),
    .addr  (idx_q),
    .wdata (bus.hwdata),
    .rdata (rd_word)
  );

  assign bus.hreadyout = ready;
  assign bus.hresp     = ((state_q == SRAM_ERR1) || (state_q == SRAM_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata    = ((state_q == SRAM_DATA) && !write_q) ? rd_word : '0;

  logic unused_bits;
  assign unused_bits = ^{bus.hburst, bus.htrans[0]};
endmodule
